// File: rtl/csr_gpio_if.sv
// CSR bus bundle between the core CSR unit (master) and a CSR-mapped peripheral (slave).
// A write is accepted on any clk edge where csr_enable=1 and the address and op are valid; there is no back-pressure.
interface csr_gpio_if;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic [31:0] csr_data_out;

    modport master (
        output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        input  csr_data_out
    );

    modport slave (
        input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        output csr_data_out
    );
endinterface

// File: rtl/csr_gpio_bank.sv
// CSR-mapped GPIO bank: per-pin direction/output, synchronised and debounced inputs,
// and rise/fall edge interrupts collected in a write-1-to-clear pending register.
module csr_gpio_bank #(
    parameter int          GpioNum        = 8,
    parameter logic [11:0] BaseAddr       = 12'h010,
    parameter int          DebounceCycles = 16
) (
    input  logic               clk,
    input  logic               reset,
    csr_gpio_if.slave          csr,
    input  logic [GpioNum-1:0] pin_in,
    output logic [GpioNum-1:0] pin_out,
    output logic [GpioNum-1:0] pin_oe,
    output logic               irq
);

    localparam int CW = (DebounceCycles > 0) ? $clog2(DebounceCycles + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((DebounceCycles > 0) ? DebounceCycles - 1 : 0);

    logic [GpioNum-1:0] dir_q, dir_d;
    logic [GpioNum-1:0] out_q, out_d;
    logic [GpioNum-1:0] rise_en_q, rise_en_d;
    logic [GpioNum-1:0] fall_en_q, fall_en_d;
    logic [GpioNum-1:0] pend_q, pend_d;
    logic [GpioNum-1:0] meta_q, sync_q;
    logic [GpioNum-1:0] stable_q, stable_d;
    logic [CW-1:0]      cnt_q [GpioNum];
    logic [CW-1:0]      cnt_d [GpioNum];
    logic               irq_q;

    logic [11:0]        off;
    logic               hit;
    logic               we;
    logic [31:0]        src32;
    logic [GpioNum-1:0] src;
    logic [GpioNum-1:0] rd_val;
    logic [GpioNum-1:0] pend_clr;
    logic [GpioNum-1:0] pend_set;

    assign off   = csr.csr_addr - BaseAddr;
    assign hit   = csr.csr_enable && (off < 12'd6);
    assign we    = hit && (csr.csr_op[1:0] != 2'b00);
    assign src32 = csr.csr_op[2] ? {27'd0, csr.rs1_zimm} : csr.rs1_data;
    assign src   = src32[GpioNum-1:0];

    function automatic logic [GpioNum-1:0] apply_op(input logic [GpioNum-1:0] old_v,
                                                    input logic [GpioNum-1:0] s,
                                                    input logic [1:0]         kind);
        case (kind)
            2'b01:   apply_op = s;
            2'b10:   apply_op = old_v | s;
            2'b11:   apply_op = old_v & ~s;
            default: apply_op = old_v;
        endcase
    endfunction

    always_comb begin
        rd_val = '0;
        case (off)
            12'd0:   rd_val = dir_q;
            12'd1:   rd_val = out_q;
            12'd2:   rd_val = stable_q;
            12'd3:   rd_val = rise_en_q;
            12'd4:   rd_val = fall_en_q;
            12'd5:   rd_val = pend_q;
            default: rd_val = '0;
        endcase
        csr.csr_data_out = hit ? 32'(rd_val) : 32'd0;
    end

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        if (we) begin
            case (off)
                12'd0: dir_d     = apply_op(dir_q, src, csr.csr_op[1:0]);
                12'd1: out_d     = apply_op(out_q, src, csr.csr_op[1:0]);
                12'd3: rise_en_d = apply_op(rise_en_q, src, csr.csr_op[1:0]);
                12'd4: fall_en_d = apply_op(fall_en_q, src, csr.csr_op[1:0]);
                // Pending bits clear wherever the op would have written or set a 1.
                12'd5: pend_clr  = (csr.csr_op[1:0] != 2'b11) ? src : '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < GpioNum; i++) begin
            cnt_d[i] = '0;
            if (DebounceCycles == 0) begin
                // Without debounce, stable acts as the second synchroniser stage.
                stable_d[i] = meta_q[i];
            end else if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Set wins over a simultaneous clear of the same pending bit.
    assign pend_set = ((stable_d & ~stable_q) & rise_en_q) | ((~stable_d & stable_q) & fall_en_q);
    assign pend_d   = (pend_q & ~pend_clr) | pend_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            meta_q    <= '0;
            sync_q    <= '0;
            stable_q  <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < GpioNum; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            meta_q    <= pin_in;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            irq_q     <= |pend_q;
            for (int i = 0; i < GpioNum; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;

endmodule
